order_msg_decoder: RTL and testbench

ORDER_MSG_DECODER -- requirements
Module: order_msg_decoder

---
 rtl/order_msg_pkg.sv | 33 +++
 rtl/order_msg_decoder.sv | 147 ++++++++++++++
 tb/tb_order_msg_decoder.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/order_msg_pkg.sv
// Shared definitions for the order-message byte stream: type codes, message lengths, FSM encoding.
// Also imported by the order-book path so both sides agree on framing.
package order_msg_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    localparam logic [7:0] MSG_ADD    = 8'h41;
    localparam logic [7:0] MSG_CANCEL = 8'h58;
    localparam logic [7:0] MSG_EXEC   = 8'h45;

    // Total message lengths including the type byte.
    localparam int LEN_ADD    = 7;
    localparam int LEN_CANCEL = 3;
    localparam int LEN_EXEC   = 5;

    function automatic logic is_msg_type(input logic [7:0] b);
        return (b == MSG_ADD) || (b == MSG_CANCEL) || (b == MSG_EXEC);
    endfunction

    // Number of field bytes that follow the type byte.
    function automatic logic [2:0] body_len(input logic [7:0] t);
        case (t)
            MSG_ADD:    return 3'(LEN_ADD - 1);
            MSG_CANCEL: return 3'(LEN_CANCEL - 1);
            MSG_EXEC:   return 3'(LEN_EXEC - 1);
            default:    return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/order_msg_decoder.sv
// Decodes big-endian add/cancel/execute messages from a never-stalling byte stream
// into one-cycle command strobes, with an inter-byte timeout and error counting.
//
// state   | meaning
// IDLE    | waiting for a type byte; bad type bytes are dropped and counted
// BODY    | collecting field bytes; byte_cnt indexes them, idle_cnt times out gaps
module order_msg_decoder
    import order_msg_pkg::*;
#(
    parameter int ID_BITS     = 10,
    parameter int DATA_BITS   = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    input  logic [7:0]           s_data,
    output logic                 s_ready,
    output logic                 ADD,
    output logic                 CANCEL,
    output logic                 EXEC,
    output logic [ID_BITS-1:0]   order_id_out,
    output logic [DATA_BITS-1:0] price_out,
    output logic [DATA_BITS-1:0] size_out,
    output logic [7:0]           err_cnt,
    output logic [15:0]          msg_cnt
);

    localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(TIMEOUT_CYC - 1);

    state_t            state;
    logic [7:0]        msg_type;
    logic [2:0]        byte_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [39:0]       field_sr;

    logic              accept;
    logic              last_byte;
    logic              id_ok;
    logic [47:0]       body;
    logic [15:0]       id_f;
    logic [15:0]       price_f;
    logic [15:0]       size_f;

    assign accept    = s_valid & s_ready;
    assign body      = {field_sr, s_data};
    assign last_byte = (byte_cnt == body_len(msg_type) - 3'd1);

    // Fields are right-aligned in body at the moment the final byte is on s_data.
    always_comb begin
        id_f    = 16'd0;
        price_f = 16'd0;
        size_f  = 16'd0;
        case (msg_type)
            MSG_ADD: begin
                id_f    = body[47:32];
                price_f = body[31:16];
                size_f  = body[15:0];
            end
            MSG_CANCEL: id_f = body[15:0];
            MSG_EXEC: begin
                id_f   = body[31:16];
                size_f = body[15:0];
            end
            default: ;
        endcase
        id_ok = ((id_f >> ID_BITS) == 16'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            msg_type     <= 8'd0;
            byte_cnt     <= 3'd0;
            idle_cnt     <= '0;
            field_sr     <= 40'd0;
            s_ready      <= 1'b0;
            ADD          <= 1'b0;
            CANCEL       <= 1'b0;
            EXEC         <= 1'b0;
            order_id_out <= '0;
            price_out    <= '0;
            size_out     <= '0;
            err_cnt      <= 8'd0;
            msg_cnt      <= 16'd0;
        end else begin
            s_ready <= 1'b1;
            ADD     <= 1'b0;
            CANCEL  <= 1'b0;
            EXEC    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_msg_type(s_data)) begin
                            msg_type <= s_data;
                            byte_cnt <= 3'd0;
                            idle_cnt <= IDLE_LOAD;
                            state    <= ST_BODY;
                        end else if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
                ST_BODY: begin
                    if (accept) begin
                        field_sr <= {field_sr[31:0], s_data};
                        idle_cnt <= IDLE_LOAD;
                        if (last_byte) begin
                            state    <= ST_IDLE;
                            byte_cnt <= 3'd0;
                            if (id_ok) begin
                                order_id_out <= id_f[ID_BITS-1:0];
                                msg_cnt      <= msg_cnt + 16'd1;
                                case (msg_type)
                                    MSG_ADD: begin
                                        ADD       <= 1'b1;
                                        price_out <= DATA_BITS'(price_f);
                                        size_out  <= DATA_BITS'(size_f);
                                    end
                                    MSG_EXEC: begin
                                        EXEC     <= 1'b1;
                                        size_out <= DATA_BITS'(size_f);
                                    end
                                    default: CANCEL <= 1'b1;
                                endcase
                            end else if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end else if (idle_cnt == '0) begin
                        state    <= ST_IDLE;
                        byte_cnt <= 3'd0;
                        if (err_cnt != 8'hFF)
                            err_cnt <= err_cnt + 8'd1;
                    end else begin
                        idle_cnt <= idle_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_order_msg_decoder.sv
// Bench for order_msg_decoder: queue-based message model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_order_msg_decoder;

    localparam int ID_BITS   = 10;
    localparam int DATA_BITS = 16;
    localparam int TIMEOUT   = 255;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 s_valid;
    logic [7:0]           s_data;
    logic                 s_ready;
    logic                 ADD, CANCEL, EXEC;
    logic [ID_BITS-1:0]   order_id_out;
    logic [DATA_BITS-1:0] price_out, size_out;
    logic [7:0]           err_cnt;
    logic [15:0]          msg_cnt;

    int errors = 0;
    int checks = 0;

    order_msg_decoder #(.ID_BITS(ID_BITS), .DATA_BITS(DATA_BITS), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .ADD(ADD), .CANCEL(CANCEL), .EXEC(EXEC), .order_id_out(order_id_out),
        .price_out(price_out), .size_out(size_out), .err_cnt(err_cnt), .msg_cnt(msg_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int msg_len(input logic [7:0] t);
        case (t)
            8'h41:   return 7;
            8'h58:   return 3;
            8'h45:   return 5;
            default: return 0;
        endcase
    endfunction

    logic [7:0] m_q[$];
    int  idle_run;
    bit  model_live = 0;
    bit  exp_ready, exp_add, exp_cancel, exp_exec;
    int  exp_id, exp_price, exp_size, exp_err, exp_msg;

    task automatic model_err();
        if (exp_err < 255) exp_err++;
    endtask

    task automatic model_finish();
        int id;
        id = {m_q[1], m_q[2]};
        if (id >= (1 << ID_BITS)) begin
            model_err();
        end else begin
            exp_id  = id;
            exp_msg = (exp_msg + 1) % 65536;
            if (m_q[0] == 8'h41) begin
                exp_add   = 1;
                exp_price = {m_q[3], m_q[4]};
                exp_size  = {m_q[5], m_q[6]};
            end else if (m_q[0] == 8'h45) begin
                exp_exec = 1;
                exp_size = {m_q[3], m_q[4]};
            end else begin
                exp_cancel = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        bit acc;
        if (!rst_n) begin
            model_live = 1;
            m_q.delete();
            idle_run = 0;
            exp_ready = 0; exp_add = 0; exp_cancel = 0; exp_exec = 0;
            exp_id = 0; exp_price = 0; exp_size = 0; exp_err = 0; exp_msg = 0;
        end else begin
            acc = s_valid && exp_ready;
            exp_ready = 1;
            exp_add = 0; exp_cancel = 0; exp_exec = 0;
            if (m_q.size() == 0) begin
                if (acc) begin
                    if (msg_len(s_data) != 0) begin
                        m_q.push_back(s_data);
                        idle_run = 0;
                    end else begin
                        model_err();
                    end
                end
            end else if (acc) begin
                m_q.push_back(s_data);
                idle_run = 0;
                if (m_q.size() == msg_len(m_q[0])) begin
                    model_finish();
                    m_q.delete();
                end
            end else begin
                idle_run++;
                if (idle_run == TIMEOUT) begin
                    m_q.delete();
                    model_err();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("s_ready", 32'(s_ready), 32'(exp_ready));
            chk("add",     32'(ADD),     32'(exp_add));
            chk("cancel",  32'(CANCEL),  32'(exp_cancel));
            chk("exec",    32'(EXEC),    32'(exp_exec));
            chk("id",      32'(order_id_out), 32'(exp_id));
            chk("price",   32'(price_out),    32'(exp_price));
            chk("size",    32'(size_out),     32'(exp_size));
            chk("err_cnt", 32'(err_cnt),      32'(exp_err));
            chk("msg_cnt", 32'(msg_cnt),      32'(exp_msg));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_data  = 8'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_strobes", 32'({ADD, CANCEL, EXEC}), 32'd0);
        chk("rst_err",     32'(err_cnt), 32'd0);
        chk("rst_msg",     32'(msg_cnt), 32'd0);
        chk("rst_id",      32'(order_id_out), 32'd0);
        rst_n = 1'b1;
    endtask

    function automatic int rand_gap();
        int r;
        r = $urandom_range(0, 99);
        if (r < 70) return 0;
        if (r < 95) return $urandom_range(1, 3);
        return $urandom_range(250, 258);
    endfunction

    function automatic logic [7:0] bad_byte();
        logic [7:0] b;
        b = 8'($urandom);
        if (msg_len(b) != 0) b = b ^ 8'h01;
        return b;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] mb[7];
        int len, trunc, r;
        logic [15:0] id, pr, sz;
        logic [7:0] t;

        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'd0;
        do_reset();

        // Scenario 1: single ADD
        send(8'h41); send(8'h00); send(8'h05); send(8'h01); send(8'h2C); send(8'h00); send(8'h64);
        idle_cyc(1);
        chk("s1_add",   32'(ADD), 32'd1);
        chk("s1_id",    32'(order_id_out), 32'd5);
        chk("s1_price", 32'(price_out), 32'd300);
        chk("s1_size",  32'(size_out), 32'd100);
        chk("s1_msg",   32'(msg_cnt), 32'd1);
        idle_cyc(1);
        chk("s1_add_drop", 32'(ADD), 32'd0);

        // Scenario 2: CANCEL then EXEC back to back
        do_reset();
        send(8'h58); send(8'h00); send(8'h05);
        send(8'h45);
        chk("s2_cancel", 32'(CANCEL), 32'd1);
        chk("s2_cid",    32'(order_id_out), 32'd5);
        send(8'h00); send(8'h07); send(8'h00); send(8'h0A);
        idle_cyc(1);
        chk("s2_exec",  32'(EXEC), 32'd1);
        chk("s2_eid",   32'(order_id_out), 32'd7);
        chk("s2_esize", 32'(size_out), 32'd10);
        chk("s2_msg",   32'(msg_cnt), 32'd2);

        // Scenario 3: bad type byte and out-of-range id
        do_reset();
        send(8'h5A); send(8'h58); send(8'h04); send(8'h00);
        idle_cyc(2);
        chk("s3_err", 32'(err_cnt), 32'd2);
        chk("s3_msg", 32'(msg_cnt), 32'd0);

        // Scenario 4: inter-byte timeout boundary
        do_reset();
        send(8'h41); send(8'h00); send(8'h01);
        idle_cyc(255);
        chk("s4_err_254", 32'(err_cnt), 32'd0);
        idle_cyc(1);
        chk("s4_err_255", 32'(err_cnt), 32'd1);
        send(8'h58); send(8'h00); send(8'h01);
        idle_cyc(1);
        chk("s4_cancel", 32'(CANCEL), 32'd1);
        chk("s4_id",     32'(order_id_out), 32'd1);

        // Scenario 5: reset mid-message
        do_reset();
        send(8'h45); send(8'h00); send(8'h03);
        do_reset();
        send(8'h58); send(8'h00); send(8'h03);
        idle_cyc(1);
        chk("s5_cancel", 32'(CANCEL), 32'd1);
        chk("s5_id",     32'(order_id_out), 32'd3);
        chk("s5_err",    32'(err_cnt), 32'd0);

        // Scenario 6: error counter saturation
        do_reset();
        repeat (300) send(bad_byte());
        idle_cyc(1);
        chk("s6_err_sat", 32'(err_cnt), 32'd255);

        // Randomized traffic
        do_reset();
        for (int m = 0; m < 250; m++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                send(bad_byte());
            end else begin
                case ($urandom_range(0, 2))
                    0:       t = 8'h41;
                    1:       t = 8'h58;
                    default: t = 8'h45;
                endcase
                r = $urandom_range(0, 19);
                if (r == 0)      id = 16'($urandom);
                else if (r == 1) id = 16'd1023;
                else if (r == 2) id = 16'd1024;
                else             id = 16'($urandom_range(0, 1023));
                pr = 16'($urandom);
                sz = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom);
                mb[0] = t; mb[1] = id[15:8]; mb[2] = id[7:0];
                if (t == 8'h41) begin
                    mb[3] = pr[15:8]; mb[4] = pr[7:0]; mb[5] = sz[15:8]; mb[6] = sz[7:0];
                end else begin
                    mb[3] = sz[15:8]; mb[4] = sz[7:0]; mb[5] = 8'd0; mb[6] = 8'd0;
                end
                len = msg_len(t);
                trunc = ($urandom_range(0, 99) < 3) ? $urandom_range(1, len - 1) : len;
                for (int i = 0; i < trunc; i++) begin
                    if (i > 0) idle_cyc(rand_gap());
                    send(mb[i]);
                end
                if (trunc < len) do_reset();
            end
            idle_cyc($urandom_range(0, 2));
        end
        idle_cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
